// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI clock generator.
// Holds the transfer FSM state type and the default divisor / bit-count widths.
package spi_pkg;
   localparam int DEF_DIV_W = 8;
   localparam int DEF_CNT_W = 6;
   typedef enum logic [1:0] {IDLE, RUN, DONE} spi_state_t;
endpackage

// File: rtl/spi_clk_tick.sv
// spi_clk_tick: half-period counter producing a one-cycle tick every i_div+1 enabled cycles.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load loads i_div;
// i_en runs the count; i_div load/reload value; o_tick terminal-count pulse.
module spi_clk_tick
   import spi_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);
   logic [DIV_W-1:0] r_cnt;
   assign o_tick = i_en && (r_cnt == '0);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cnt <= '0;
      else if (i_load || o_tick) r_cnt <= i_div;
      else if (i_en) r_cnt <= r_cnt - DIV_W'(1);
   end
endmodule

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SPI master clock generator with leading/trailing and sample/shift strobes.
// Ports: m_clk system clock; nrst async active-low reset; start/abort transfer control;
// cpol/cpha SPI mode; div half-period minus one; nbits clock periods per transfer;
// spi_clk generated clock; lead_stb/trail_stb edge strobes; sample_stb/shift_stb
// mode-mapped strobes; busy transfer active; done normal-completion pulse.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             m_clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             abort,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] nbits,
   output logic             spi_clk,
   output logic             lead_stb,
   output logic             trail_stb,
   output logic             sample_stb,
   output logic             shift_stb,
   output logic             busy,
   output logic             done
);
   spi_state_t       r_state, w_next;
   logic [DIV_W-1:0] r_div;
   logic [CNT_W-1:0] r_nbits;
   logic [CNT_W:0]   r_tog, w_tog_nx;
   logic             r_cpol, r_cpha, r_spi, r_lead, r_trail, r_sample, r_shift, r_busy, r_done;
   logic             w_accept, w_tick, w_toggle, w_last, w_lead, w_trail;
   assign w_accept = (r_state == IDLE) && start && !abort;
   // abort wins over a coincident tick so the return to idle carries no strobe
   assign w_toggle = (r_state == RUN) && !abort && w_tick;
   // one extra count bit keeps 2*nbits representable at the largest nbits
   assign w_tog_nx = r_tog + (CNT_W+1)'(1);
   assign w_last   = w_toggle && (w_tog_nx == {r_nbits, 1'b0});
   assign w_lead   = w_toggle && (r_spi == r_cpol);
   assign w_trail  = w_toggle && (r_spi != r_cpol);
   spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
      .i_clk  (m_clk),
      .i_rst_n(nrst),
      .i_load (w_accept),
      .i_en   (r_state == RUN),
      .i_div  (w_accept ? div : r_div),
      .o_tick (w_tick)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? ((nbits != '0) ? RUN : DONE) : IDLE;
         RUN:     w_next = abort ? IDLE : (w_last ? DONE : RUN);
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge m_clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= IDLE;
         r_div    <= '0;
         r_nbits  <= '0;
         r_tog    <= '0;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_spi    <= 1'b0;
         r_lead   <= 1'b0;
         r_trail  <= 1'b0;
         r_sample <= 1'b0;
         r_shift  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_busy   <= (w_next == RUN);
         // done trails the state by one cycle: it marks the cycle spent in DONE
         r_done   <= (r_state == DONE);
         r_lead   <= w_lead;
         r_trail  <= w_trail;
         r_sample <= r_cpha ? w_trail : w_lead;
         r_shift  <= r_cpha ? w_lead : w_trail;
         r_spi    <= (r_state == IDLE) ? cpol : ((r_state == RUN) && abort) ? r_cpol : r_spi ^ w_toggle;
         if (w_accept) begin
            r_div   <= div;
            r_nbits <= nbits;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_tog   <= '0;
         end else if (w_toggle) r_tog <= w_tog_nx;
      end
   end
   assign spi_clk    = r_spi;
   assign lead_stb   = r_lead;
   assign trail_stb  = r_trail;
   assign sample_stb = r_sample;
   assign shift_stb  = r_shift;
   assign busy       = r_busy;
   assign done       = r_done;
endmodule

// File: tb/tb_spi_clk_gen.sv
// tb_spi_clk_gen: directed self-checking bench for spi_clk_gen (default and narrow widths).
module tb_spi_clk_gen;
   logic       m_clk = 0, nrst = 0;
   logic       start_a = 0, abort_a = 0, cpol_a = 1, cpha_a = 0;
   logic [7:0] div_a = 0;
   logic [5:0] nbits_a = 0;
   logic       start_b = 0, abort_b = 0, cpol_b = 0, cpha_b = 0;
   logic [3:0] div_b = 0;
   logic [1:0] nbits_b = 0;
   wire  [6:0] oa, ob;
   int         total = 0, bad = 0, cyc = 0, t_acc = 0;
   int         n_tog[2], t_first[2], t_last[2], gmin[2], gmax[2], n_good[2], n_nostb[2], n_bad[2];
   int         n_samp[2], n_shift[2], n_samp_rise[2], n_done[2], t_done[2], n_busy[2];
   logic       prev[2], m_cpol[2], m_cpha[2];
   spi_clk_gen u_a (
      .m_clk(m_clk), .nrst(nrst), .start(start_a), .abort(abort_a), .cpol(cpol_a), .cpha(cpha_a),
      .div(div_a), .nbits(nbits_a), .spi_clk(oa[6]), .lead_stb(oa[5]), .trail_stb(oa[4]),
      .sample_stb(oa[3]), .shift_stb(oa[2]), .busy(oa[1]), .done(oa[0])
   );
   spi_clk_gen #(.DIV_W(4), .CNT_W(2)) u_b (
      .m_clk(m_clk), .nrst(nrst), .start(start_b), .abort(abort_b), .cpol(cpol_b), .cpha(cpha_b),
      .div(div_b), .nbits(nbits_b), .spi_clk(ob[6]), .lead_stb(ob[5]), .trail_stb(ob[4]),
      .sample_stb(ob[3]), .shift_stb(ob[2]), .busy(ob[1]), .done(ob[0])
   );
   always #5 m_clk = ~m_clk;
   always @(posedge m_clk) cyc++;
   always @(negedge m_clk) begin : mon
      logic [6:0] v;
      logic       le, se;
      for (int k = 0; k < 2; k++) begin
         v = (k == 0) ? oa : ob;
         if (v[1]) n_busy[k]++;
         if (v[0]) begin n_done[k]++; t_done[k] = cyc; end
         if (v[3]) n_samp[k]++;
         if (v[2]) n_shift[k]++;
         if (v[3] && v[6]) n_samp_rise[k]++;
         if (v[6] != prev[k]) begin
            le = (v[6] != m_cpol[k]);
            se = m_cpha[k] ? !le : le;
            n_tog[k]++;
            if (n_tog[k] == 1) t_first[k] = cyc;
            else begin
               if (cyc - t_last[k] < gmin[k]) gmin[k] = cyc - t_last[k];
               if (cyc - t_last[k] > gmax[k]) gmax[k] = cyc - t_last[k];
            end
            t_last[k] = cyc;
            if (v[5:2] == {le, !le, se, !se}) n_good[k]++;
            else if (v[5:2] == 4'b0) n_nostb[k]++;
            else n_bad[k]++;
         end else if (v[5:2] != 4'b0) n_bad[k]++;
         prev[k] = v[6];
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic clr(input int k);
      prev[k] = (k == 0) ? oa[6] : ob[6];
      n_tog[k] = 0; t_first[k] = 0; t_last[k] = 0; gmin[k] = 9999; gmax[k] = 0;
      n_good[k] = 0; n_nostb[k] = 0; n_bad[k] = 0; n_samp[k] = 0; n_shift[k] = 0;
      n_samp_rise[k] = 0; n_done[k] = 0; t_done[k] = 0; n_busy[k] = 0;
   endtask
   task automatic pulse(input int k);
      @(negedge m_clk); #1;
      clr(k);
      if (k == 0) start_a = 1; else start_b = 1;
      @(negedge m_clk);
      start_a = 0;
      start_b = 0;
      t_acc = cyc;
   endtask
   initial begin
      clr(0);
      clr(1);
      #12 chk("rst_outputs", oa, 0);
      chk("rst_outputs_b", ob, 0);
      @(negedge m_clk) nrst = 1;
      @(negedge m_clk) chk("rel_cpol1", oa[6], 1);
      cpol_a = 0;
      @(negedge m_clk) chk("idle_cpol0", oa[6], 0);
      // div=4 nbits=8 mode 0; inputs change after acceptance, start pulsed in DONE
      m_cpol[0] = 0; m_cpha[0] = 0; div_a = 4; nbits_a = 8;
      pulse(0);
      chk("t1_busy", oa[1], 1);
      div_a = 0; nbits_a = 1; cpha_a = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge m_clk);
         start_a = (cyc == t_acc + 80);
      end
      #1;
      chk("t1_tog", n_tog[0], 16);
      chk("t1_first", t_first[0] - t_acc, 5);
      chk("t1_gmin", gmin[0], 5);
      chk("t1_gmax", gmax[0], 5);
      chk("t1_good", n_good[0], 16);
      chk("t1_samp_rise", n_samp_rise[0], 8);
      chk("t1_samp", n_samp[0], 8);
      chk("t1_done_n", n_done[0], 1);
      chk("t1_done_at", t_done[0] - t_acc, 81);
      chk("t1_end_clk", oa[6], 0);
      // div=0 nbits=3 mode 3
      cpol_a = 1; cpha_a = 1; div_a = 0; nbits_a = 3;
      repeat (3) @(negedge m_clk);
      m_cpol[0] = 1; m_cpha[0] = 1;
      pulse(0);
      repeat (20) @(negedge m_clk);
      #1;
      chk("t2_tog", n_tog[0], 6);
      chk("t2_first", t_first[0] - t_acc, 1);
      chk("t2_gmax", gmax[0], 1);
      chk("t2_samp_rise", n_samp_rise[0], 3);
      chk("t2_shift", n_shift[0], 3);
      chk("t2_good", n_good[0], 6);
      chk("t2_done_at", t_done[0] - t_acc, 7);
      chk("t2_end_clk", oa[6], 1);
      // nbits=0
      cpol_a = 0; cpha_a = 0; div_a = 3; nbits_a = 0;
      repeat (3) @(negedge m_clk);
      m_cpol[0] = 0; m_cpha[0] = 0;
      pulse(0);
      repeat (10) @(negedge m_clk);
      #1;
      chk("t3_tog", n_tog[0], 0);
      chk("t3_busy", n_busy[0], 0);
      chk("t3_done_n", n_done[0], 1);
      chk("t3_done_at", t_done[0] - t_acc, 1);
      // start with abort in IDLE
      nbits_a = 4;
      @(negedge m_clk); #1;
      clr(0);
      start_a = 1; abort_a = 1;
      @(negedge m_clk);
      start_a = 0; abort_a = 0;
      repeat (20) @(negedge m_clk);
      #1;
      chk("t3b_tog", n_tog[0], 0);
      chk("t3b_busy", n_busy[0], 0);
      chk("t3b_done", n_done[0], 0);
      // abort after 5 toggles with an ignored start mid-run
      div_a = 2; nbits_a = 8;
      pulse(0);
      for (int i = 0; i < 45; i++) begin
         @(negedge m_clk);
         if (cyc == t_acc + 16) begin
            chk("t4_abort_clk", oa[6], 0);
            chk("t4_abort_busy", oa[1], 0);
         end
         start_a = (cyc == t_acc + 7);
         abort_a = (cyc == t_acc + 15);
      end
      #1;
      chk("t4_tog", n_tog[0], 6);
      chk("t4_good", n_good[0], 5);
      chk("t4_nostb", n_nostb[0], 1);
      chk("t4_bad", n_bad[0], 0);
      chk("t4_done", n_done[0], 0);
      chk("t4_busy", n_busy[0], 16);
      // reset mid-run
      cpol_a = 1; div_a = 3; nbits_a = 8;
      repeat (3) @(negedge m_clk);
      m_cpol[0] = 1;
      pulse(0);
      repeat (10) @(negedge m_clk);
      chk("t5_pre", oa[6:1], 6'b100001);
      #2 nrst = 0;
      #1 chk("t5_rst_async", oa, 0);
      @(negedge m_clk) chk("t5_rst_hold", oa, 0);
      nrst = 1;
      @(negedge m_clk) chk("t5_rel_clk", oa[6], 1);
      chk("t5_rel_busy", oa[1], 0);
      repeat (30) @(negedge m_clk);
      #1;
      chk("t5_done", n_done[0], 0);
      chk("t5_end", oa[6:1], 6'b100000);
      // narrow instance: div=15 nbits=3
      m_cpol[1] = 0; m_cpha[1] = 0; div_b = 15; nbits_b = 3;
      pulse(1);
      repeat (110) @(negedge m_clk);
      #1;
      chk("t6_tog", n_tog[1], 6);
      chk("t6_first", t_first[1] - t_acc, 16);
      chk("t6_gmin", gmin[1], 16);
      chk("t6_gmax", gmax[1], 16);
      chk("t6_good", n_good[1], 6);
      chk("t6_done_at", t_done[1] - t_acc, 97);
      chk("t6_end_clk", ob[6], 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_clk_gen.md
SPI_CLK_GEN -- requirements
Module: spi_clk_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of the runtime half-period divisor.
REQ-002 Parameter CNT_W, default 6, width of the transfer bit count.
REQ-003 m_clk  input  1  system clock; all logic on its rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one transfer; sampled only in IDLE.
REQ-006 abort  input  1  terminate the current transfer.
REQ-007 cpol  input  1  SPI idle clock level.
REQ-008 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-009 div  input  DIV_W  half-period length minus one, in m_clk cycles.
REQ-010 nbits  input  CNT_W  number of SPI clock periods in the transfer.
REQ-011 spi_clk  output  1  generated SPI clock, registered.
REQ-012 lead_stb  output  1  one-cycle pulse when spi_clk leaves its idle level.
REQ-013 trail_stb  output  1  one-cycle pulse when spi_clk returns to its idle level.
REQ-014 sample_stb  output  1  lead_stb when cpha=0, trail_stb when cpha=1.
REQ-015 shift_stb  output  1  the complement choice of sample_stb.
REQ-016 busy  output  1  high while a transfer is active.
REQ-017 done  output  1  one-cycle pulse when a transfer completes normally.

Function
REQ-018 The FSM SHALL have three states:
- IDLE -> RUN on start with nbits != 0.
- IDLE -> DONE on start with nbits = 0.
- RUN -> DONE after the final toggle.
- RUN -> IDLE on abort.
- DONE -> IDLE unconditionally.
REQ-019 On start acceptance, div, nbits, cpol and cpha SHALL be latched; input changes have no effect until the next acceptance.
REQ-020 In IDLE, spi_clk SHALL equal the cpol input, registered one cycle.
REQ-021 In RUN, spi_clk SHALL toggle every div+1 m_clk cycles; div=0 toggles every cycle; div=2^DIV_W-1 toggles every 2^DIV_W cycles.
REQ-022 The first toggle SHALL be registered on the (div+1)th rising m_clk after the accepting edge.
REQ-023 A transfer SHALL contain exactly 2*nbits toggles and end with spi_clk at the latched cpol.
REQ-024 The toggle count SHALL be CNT_W+1 bits wide, so nbits = 2^CNT_W-1 causes no wrap-around.
REQ-025 All strobes SHALL be registered and assert in the same cycle spi_clk changes.
REQ-026 Exactly one of sample_stb and shift_stb SHALL pulse per toggle.
REQ-027 busy SHALL be 1 from the cycle after acceptance through the last RUN cycle; busy=0 in IDLE and DONE.
REQ-028 done SHALL pulse for one cycle in DONE, i.e. the cycle after the final toggle; with nbits=0 it pulses the cycle after acceptance, with no toggles.
REQ-029 start while busy, or in DONE, SHALL be ignored and not queued.
REQ-030 On abort in RUN:
- next state IDLE.
- spi_clk returns to cpol the next cycle.
- no strobe is emitted for that return.
- done does not pulse.
REQ-031 abort and start asserted together in IDLE SHALL be treated as abort: no transfer starts.
REQ-032 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-033 While nrst=0, regardless of m_clk:
- state = IDLE.
- spi_clk, all strobes, busy and done = 0.
- counters and latched fields = 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no done pulse.
REQ-035 After reset release, the first cycle SHALL load spi_clk from cpol.

Structure
REQ-036 A shared package spi_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DONE).
- default values for DIV_W and CNT_W.
REQ-037 The half-period counter SHALL be a sub-module spi_clk_tick: load on start, reload on terminal count, one-cycle tick output.
REQ-038 Total RTL SHALL be 120-400 lines.

Verification
REQ-039 div=4, nbits=8, cpol=0, cpha=0, start pulse:
- 16 toggles, each 5 cycles apart; first toggle 5 cycles after acceptance.
- 8 sample_stb on rising edges.
- done pulses at acceptance+81 cycles.
REQ-040 div=0, nbits=3, cpol=1, cpha=1:
- spi_clk toggles every cycle, 6 toggles, ending high.
- sample_stb on the 3 rising (trailing) edges; shift_stb on the 3 falling edges.
REQ-041 nbits=0, start pulse: no toggles, busy stays 0, done pulses once at the cycle after acceptance.
REQ-042 Abort after 5 toggles (div=2, nbits=8, cpol=0):
- spi_clk = 0 and busy = 0 the next cycle.
- no done pulse; an ignored start issued mid-run does not retrigger.
REQ-043 nrst pulsed low mid-RUN: outputs reach 0 asynchronously; after release, spi_clk follows cpol=1 one cycle later.
REQ-044 DIV_W=4, CNT_W=2, div=15, nbits=3: 6 toggles, 16 cycles apart, toggle count reaches 6 without wrap-around.
